i2s_dac_transmitter: RTL
========================

I2S_DAC_TRANSMITTER -- requirements
Module: i2s_dac_transmitter

Interface
REQ-001 Port CLK, input, 1 bit, SHALL be the single system clock; all state SHALL be clocked on the rising edge of CLK.
REQ-002 Port RESET, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-003 Port AUD_BCLK, input, 1 bit, SHALL be the codec bit clock (codec master), asynchronous to CLK, at most CLK/4.
REQ-004 Port AUD_DACLRCK, input, 1 bit, SHALL be the codec DAC word clock: low = left, high = right; it transitions coincident with an AUD_BCLK falling edge.
REQ-005 Port left_frame, input, 16 bits, SHALL be the signed left sample, sampled on handshake.
REQ-006 Port right_frame, input, 16 bits, SHALL be the signed right sample, sampled on handshake.
REQ-007 Port frame_valid, input, 1 bit, SHALL mean the left/right pair is offered.
REQ-008 Port frame_ready, output, 1 bit, SHALL be high when the holding register is empty.
REQ-009 Port AUD_DACDAT, output, 1 bit, SHALL be the registered serial data to the codec.
REQ-010 Port underrun, output, 1 bit, SHALL be a one-CLK pulse when a period starts with no new pair.

Function
REQ-011 AUD_BCLK and AUD_DACLRCK SHALL each pass through a 2-flop synchronizer of identical depth, plus one flop for edge detection, so coincident transitions are detected in the same CLK cycle.
REQ-012 Handshake SHALL be: pair accepted in the cycle frame_valid and frame_ready are both high; the holding register is then full and frame_ready is low until the holding register is consumed.
REQ-013 The state machine SHALL have three states: IDLE, LEFT and RIGHT.
REQ-014 IDLE SHALL move to LEFT on a detected AUD_DACLRCK falling edge; an AUD_DACLRCK rising edge SHALL leave the state in IDLE.
REQ-015 LEFT SHALL move to RIGHT on an AUD_DACLRCK rising edge.
REQ-016 RIGHT SHALL move to LEFT on an AUD_DACLRCK falling edge.
REQ-017 On each AUD_DACLRCK falling edge, if the holding register is full, the pair SHALL be copied to the left/right shift registers and to last-pair storage, and the holding register cleared.
REQ-018 On each AUD_DACLRCK falling edge, if the holding register is empty, the last pair SHALL be reloaded and underrun pulsed for exactly one cycle.
REQ-019 An accept in the same cycle as an AUD_DACLRCK falling edge with the holding register empty SHALL count as an underrun for that period; the accepted pair SHALL remain in the holding register for the next period.
REQ-020 On any AUD_DACLRCK edge, the bit counter SHALL be cleared and AUD_DACDAT driven 0; a BCLK falling edge detected in that same cycle SHALL NOT advance the counter.
REQ-021 Each subsequent BCLK falling edge with counter k<16 SHALL drive bit (15-k) of the current channel (MSB first, one-BCLK I2S delay) and increment k.
REQ-022 BCLK falling edges with k=16 SHALL drive 0 until the next AUD_DACLRCK edge; k SHALL saturate at 16, with no wrap.
REQ-023 In IDLE, AUD_DACDAT SHALL be 0 and BCLK edges SHALL be ignored.
REQ-024 Samples SHALL be transmitted bit-exact; there is no arithmetic or clipping on the data path.
REQ-025 Latency SHALL be: an accepted pair starts serializing at the first AUD_DACLRCK falling edge after acceptance.

Reset
REQ-026 RESET high SHALL immediately force IDLE, AUD_DACDAT=0, underrun=0, frame_ready=1, the holding register empty, and shift, last-pair, counter and synchronizer flops to 0.
REQ-027 After RESET falls mid-frame, output SHALL resume only at the next detected AUD_DACLRCK falling edge; a partial channel SHALL NOT be completed.

Verification
REQ-028 Load L=16'h8001, R=16'h7FFE in IDLE; BCLK=CLK/8, 32 BCLK per channel -> at falling edges 1-16 after the LRCK fall, DACDAT carries the bits of 8001 MSB first; edges 17-31 drive 0; the right channel carries the bits of 7FFE.
REQ-029 No pair offered before the second LRCK fall -> 8001/7FFE retransmitted and underrun high exactly 1 CLK cycle.
REQ-030 Hold frame_valid high with new pairs while frame_ready is low -> only the first pair is accepted per period, frame_ready rises 1 cycle after the LRCK fall, and the accepted data matches the value offered at handshake.
REQ-031 Accept L=16'h1234 in the same cycle as the LRCK fall with the holding register empty -> underrun pulse, previous pair played, 1234 played in the following period.
REQ-032 Assert RESET at left bit 8 -> DACDAT=0 and frame_ready=1 without a CLK edge; after release with LRCK high, DACDAT stays 0 through the right phase; with no pair, the first left word is 16'h0000 and underrun pulses.
REQ-033 LRCK rising edge first after reset -> stays IDLE and DACDAT=0 until the LRCK falling edge.

Source files
------------

// File: rtl/i2s_dac_transmitter.sv
// i2s_dac_transmitter: serializes a buffered signed stereo pair to an I2S codec DAC
// whose bit clock and word clock are mastered by the codec.
module i2s_dac_transmitter (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        AUD_BCLK,
    input  logic        AUD_DACLRCK,
    input  logic [15:0] left_frame,
    input  logic [15:0] right_frame,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic        AUD_DACDAT,
    output logic        underrun
);
    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
    state_t      state;
    logic [2:0]  bclk_s, lrck_s;
    logic        hold_full;
    logic [15:0] hold_l, hold_r, shift_l, shift_r, last_l, last_r;
    logic [4:0]  cnt;
    logic        bclk_fall, lrck_fall, lrck_rise, accept, cur_bit;
    // Bit [2] is the edge-detect flop; equal depth keeps coincident BCLK/LRCK edges aligned.
    assign bclk_fall   = bclk_s[2] & ~bclk_s[1];
    assign lrck_fall   = lrck_s[2] & ~lrck_s[1];
    assign lrck_rise   = ~lrck_s[2] & lrck_s[1];
    assign frame_ready = ~hold_full;
    assign accept      = frame_valid & frame_ready;
    assign cur_bit     = (state == LEFT) ? shift_l[4'd15 - cnt[3:0]] : shift_r[4'd15 - cnt[3:0]];
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            bclk_s     <= '0;
            lrck_s     <= '0;
            hold_full  <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            shift_l    <= '0;
            shift_r    <= '0;
            last_l     <= '0;
            last_r     <= '0;
            cnt        <= '0;
            AUD_DACDAT <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            bclk_s   <= {bclk_s[1:0], AUD_BCLK};
            lrck_s   <= {lrck_s[1:0], AUD_DACLRCK};
            underrun <= lrck_fall & ~hold_full;
            if (lrck_fall) begin
                state <= LEFT;
                if (hold_full) begin
                    shift_l   <= hold_l;
                    shift_r   <= hold_r;
                    last_l    <= hold_l;
                    last_r    <= hold_r;
                    hold_full <= 1'b0;
                end else begin
                    shift_l <= last_l;
                    shift_r <= last_r;
                end
            end else if (lrck_rise && state != IDLE) begin
                state <= RIGHT;
            end
            // A pair accepted on an empty-register fall waits for the following period.
            if (accept) begin
                hold_l    <= left_frame;
                hold_r    <= right_frame;
                hold_full <= 1'b1;
            end
            if (lrck_fall || lrck_rise) begin
                cnt        <= '0;
                AUD_DACDAT <= 1'b0;
            end else if (state != IDLE && bclk_fall) begin
                if (cnt[4]) begin
                    AUD_DACDAT <= 1'b0;
                end else begin
                    AUD_DACDAT <= cur_bit;
                    cnt        <= cnt + 5'd1;
                end
            end
        end
    end
endmodule
